// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared constants, conversion state and double-dabble step
package bcd_disp_pkg;
    localparam int NUM_DIG = 4;
    localparam int DIG_W   = 4;
    localparam int MAX_VAL = 9999;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit
    function automatic logic [NUM_DIG*DIG_W-1:0] dd_step(input logic [NUM_DIG*DIG_W-1:0] bcd, input logic b);
        logic [NUM_DIG*DIG_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < NUM_DIG; i++)
            adj[DIG_W*i +: DIG_W] = (bcd[DIG_W*i +: DIG_W] > 4'd4) ? bcd[DIG_W*i +: DIG_W] + 4'd3 : bcd[DIG_W*i +: DIG_W];
        return {adj[NUM_DIG*DIG_W-2:0], b};
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per clock
module bin2bcd_seq
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BIN_W-1:0]         bin_in,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_DIG*DIG_W-1:0] bcd_out
);
    localparam int CW = $clog2(BIN_W + 1);

    conv_state_t              state, state_n;
    logic [BIN_W-1:0]         sr;
    logic [NUM_DIG*DIG_W-1:0] bcd;
    logic [CW-1:0]            cnt;

    // The first iteration happens on the start edge, so SHIFT needs BIN_W-1 more and DONE lands result on edge N+BIN_W
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SHIFT : IDLE;
            SHIFT:   state_n = (cnt == CW'(BIN_W - 2)) ? DONE : SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Shift/add-3 datapath and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            bcd <= dd_step('0, bin_in[BIN_W-1]);
            sr  <= bin_in << 1;
            cnt <= '0;
        end else if (state == SHIFT) begin
            bcd <= dd_step(bcd, sr[BIN_W-1]);
            sr  <= sr << 1;
            cnt <= cnt + 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign bcd_out = bcd;
endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: load gate, saturation, atomic display register and 4-digit scan
module bcd_scan_driver
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BIN_W-1:0]   Value_In,
    input  logic               Load,
    output logic               Busy,
    output logic               Overflow,
    output logic [DIG_W-1:0]   Bin,
    output logic [NUM_DIG-1:0] Anode
);
    localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAX_VAL);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIG);

    logic                     accept, ovf_in, done, wrap, lit;
    logic [BIN_W-1:0]         sat;
    logic [NUM_DIG*DIG_W-1:0] conv_bcd, disp, disp_n;
    logic [SW-1:0]            scan_cnt;
    logic [IW-1:0]            idx, idx_n;
    logic [DIG_W-1:0]         bin_n;
    logic [NUM_DIG-1:0]       anode_n;

    assign accept = Load & ~Busy;
    assign ovf_in = (Value_In > MAXV);
    assign sat    = ovf_in ? MAXV : Value_In;

    bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .bin_in  (sat),
        .busy    (Busy),
        .done    (done),
        .bcd_out (conv_bcd)
    );

    // Next digit index, next display and the blanked/lit decision for the digit about to be shown
    always_comb begin
        wrap    = (scan_cnt == SW'(SCAN_DIV - 1));
        idx_n   = wrap ? idx + 1'b1 : idx;
        disp_n  = done ? conv_bcd : disp;
        bin_n   = disp_n[DIG_W*idx_n +: DIG_W];
        lit     = (idx_n == '0) || (BLANK_LZ == 0) || (|(disp_n >> (DIG_W*idx_n)));
        anode_n = lit ? ~(NUM_DIG'(1) << idx_n) : '1;
    end

    // Scan counter, display register and registered Bin/Anode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            disp     <= '0;
            Overflow <= 1'b0;
            Bin      <= '0;
            Anode    <= ~NUM_DIG'(1);
        end else begin
            scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
            idx      <= idx_n;
            disp     <= disp_n;
            Bin      <= bin_n;
            Anode    <= anode_n;
            if (accept) Overflow <= ovf_in;
        end
    end
endmodule
